// File: rtl/loop_pipeline_sequencer.sv
// loop_pipeline_sequencer: issues tagged calls to loop_pipeline and returns in-order tagged results.
module loop_pipeline_sequencer #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_base,
  input  logic [7:0]  cmd_tag,
  output logic        start,
  output logic [63:0] A,
  input  logic        busy,
  input  logic        done,
  output logic        stall,
  input  logic [19:0] returndata,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [19:0] res_data,
  output logic [7:0]  res_tag,
  output logic [3:0]  outstanding,
  output logic        err
);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  logic [7:0]    tags [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          ret, ret_ok, bad;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    cmd_ready = !reset && outstanding < 4'(MAX_OUTSTANDING) && !busy;
    start     = cmd_valid && cmd_ready;
    A         = cmd_base;
    stall     = res_valid && !res_ready;
    ret       = done && !stall;
    ret_ok    = ret && outstanding != 4'd0;
    bad       = ret && outstanding == 4'd0;
  end
  always_ff @(posedge clock)
    if (start) tags[wr_ptr] <= cmd_tag;
  // A return with nothing in flight only flags err; the pipeline state is left untouched
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_tag     <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (start) wr_ptr <= nxt(wr_ptr);
      if (ret_ok) begin
        res_data <= returndata;
        res_tag  <= tags[rd_ptr];
        rd_ptr   <= nxt(rd_ptr);
      end
      res_valid   <= ret_ok || (res_valid && !res_ready);
      outstanding <= outstanding + 4'(start && !ret_ok) - 4'(ret_ok && !start);
      err         <= err || bad;
    end
  end
endmodule

// File: tb/tb_loop_pipeline_sequencer.sv
// tb_loop_pipeline_sequencer: directed checks of call issue, result return, backpressure, errors and reset.
module tb_loop_pipeline_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [63:0] cmd_base = '0;
  logic [7:0]  cmd_tag = '0;
  logic        start;
  logic [63:0] A;
  logic        busy = 1'b0;
  logic        done = 1'b0;
  logic        stall;
  logic [19:0] returndata = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [19:0] res_data;
  logic [7:0]  res_tag;
  logic [3:0]  outstanding;
  logic        err;
  int checks = 0;
  int errors = 0;

  loop_pipeline_sequencer #(.MAX_OUTSTANDING(4)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_tag(cmd_tag), .start(start), .A(A), .busy(busy),
    .done(done), .stall(stall), .returndata(returndata), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .outstanding(outstanding), .err(err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    cmd_valid = 1'b1;
    step();
    step();
    check("rst_outstanding", outstanding, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_tag", res_tag, 0);
    check("rst_err", err, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_start", start, 0);
    check("rst_stall", stall, 0);
    reset = 1'b0;
    cmd_valid = 1'b0;
    step();

    // single call
    cmd_valid = 1'b1; cmd_base = 64'h1000; cmd_tag = 8'h5A;
    #1;
    check("single_ready", cmd_ready, 1);
    check("single_start", start, 1);
    check("single_A", A, 64'h1000);
    step();
    cmd_valid = 1'b0;
    check("single_out1", outstanding, 1);
    step();
    done = 1'b1; returndata = 20'h00ABC;
    #1;
    check("single_stall", stall, 0);
    step();
    done = 1'b0;
    check("single_valid", res_valid, 1);
    check("single_data", res_data, 20'h00ABC);
    check("single_tag", res_tag, 8'h5A);
    check("single_out0", outstanding, 0);
    step();
    check("single_consumed", res_valid, 0);

    // fill to MAX_OUTSTANDING
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_tag = 8'h10 + 8'(i);
      #1;
      check("fill_ready", cmd_ready, 1);
      step();
    end
    cmd_tag = 8'h14;
    #1;
    check("full_ready", cmd_ready, 0);
    check("full_start", start, 0);
    check("full_out", outstanding, 4);
    done = 1'b1; returndata = 20'h11111;
    #1;
    check("full_no_bypass", cmd_ready, 0);
    step();
    done = 1'b0;
    #1;
    check("full_out3", outstanding, 3);
    check("full_res_tag", res_tag, 8'h10);
    check("freed_ready", cmd_ready, 1);
    check("freed_start", start, 1);
    step();
    cmd_valid = 1'b0;
    check("refill_out", outstanding, 4);
    check("refill_consumed", res_valid, 0);

    // backpressure
    res_ready = 1'b0; done = 1'b1; returndata = 20'h22222;
    step();
    check("bp_valid", res_valid, 1);
    check("bp_tag", res_tag, 8'h11);
    check("bp_data", res_data, 20'h22222);
    returndata = 20'h33333;
    #1;
    check("bp_stall", stall, 1);
    step();
    step();
    check("bp_hold_data", res_data, 20'h22222);
    check("bp_hold_tag", res_tag, 8'h11);
    check("bp_no_pop", outstanding, 3);
    res_ready = 1'b1;
    #1;
    check("bp_release_stall", stall, 0);
    step();
    check("bp_next_data", res_data, 20'h33333);
    check("bp_next_tag", res_tag, 8'h12);
    check("bp_next_valid", res_valid, 1);
    check("bp_out2", outstanding, 2);
    returndata = 20'h44444;
    step();
    check("b2b_tag1", res_tag, 8'h13);
    check("b2b_data1", res_data, 20'h44444);
    returndata = 20'h55555;
    step();
    check("b2b_tag2", res_tag, 8'h14);
    check("b2b_valid2", res_valid, 1);
    check("b2b_out0", outstanding, 0);
    done = 1'b0;
    step();
    check("b2b_drained", res_valid, 0);

    // ordering across FIFO wrap
    for (int k = 0; k <= 10; k++) begin
      cmd_valid = (k < 10); cmd_tag = 8'(k);
      done = (k >= 1); returndata = 20'h00100 + 20'(k);
      step();
      if (k >= 1) begin
        check("ord_valid", res_valid, 1);
        check("ord_tag", res_tag, 64'(k - 1));
        check("ord_data", res_data, 64'h100 + 64'(k));
      end
    end
    cmd_valid = 1'b0; done = 1'b0;
    step();
    check("ord_drained", res_valid, 0);
    check("ord_out0", outstanding, 0);
    check("ord_no_err", err, 0);

    // return with nothing in flight
    done = 1'b1; returndata = 20'hEEEEE;
    step();
    check("err_set", err, 1);
    check("err_no_valid", res_valid, 0);
    check("err_out0", outstanding, 0);
    done = 1'b0;
    step();
    check("err_sticky", err, 1);
    cmd_valid = 1'b1; cmd_tag = 8'h77; done = 1'b1;
    step();
    check("err_accept_out", outstanding, 1);
    check("err_accept_novalid", res_valid, 0);
    cmd_valid = 1'b0; returndata = 20'h77777;
    step();
    done = 1'b0;
    check("err_pushed_tag", res_tag, 8'h77);
    check("err_pushed_data", res_data, 20'h77777);
    check("err_still", err, 1);
    check("err_out_back0", outstanding, 0);

    // busy gating and mid-run reset
    busy = 1'b1; cmd_valid = 1'b1; cmd_tag = 8'hA0;
    #1;
    check("busy_ready", cmd_ready, 0);
    check("busy_start", start, 0);
    step();
    check("busy_out0", outstanding, 0);
    busy = 1'b0;
    step();
    step();
    step();
    check("pre_rst_out", outstanding, 3);
    reset = 1'b1;
    #1;
    check("in_rst_ready", cmd_ready, 0);
    check("in_rst_start", start, 0);
    step();
    check("mid_rst_out", outstanding, 0);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_err", err, 0);
    reset = 1'b0; cmd_valid = 1'b1; cmd_tag = 8'hC3;
    step();
    cmd_valid = 1'b0; done = 1'b1; returndata = 20'h0C3C3;
    step();
    done = 1'b0;
    check("post_rst_tag", res_tag, 8'hC3);
    check("post_rst_data", res_data, 20'h0C3C3);
    check("post_rst_out", outstanding, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/loop_pipeline_sequencer.md
LOOP_PIPELINE_SEQUENCER -- requirements
Module: loop_pipeline_sequencer

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 4, legal 1..15; maximum calls in flight to loop_pipeline and depth of the tag FIFO.
REQ-002 clock  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted this cycle when cmd_valid=1.
REQ-006 cmd_base  in  64  array base address for the call.
REQ-007 cmd_tag  in  8  caller tag, returned with the result.
REQ-008 start  out  1  loop_pipeline call.valid.
REQ-009 A  out  64  loop_pipeline A.data.
REQ-010 busy  in  1  loop_pipeline call.stall.
REQ-011 done  in  1  loop_pipeline return.valid.
REQ-012 stall  out  1  loop_pipeline return.stall.
REQ-013 returndata  in  20  loop_pipeline return data.
REQ-014 res_valid  out  1  result available.
REQ-015 res_ready  in  1  result consumer ready.
REQ-016 res_data  out  20  result value.
REQ-017 res_tag  out  8  tag of the call producing res_data.
REQ-018 outstanding  out  4  calls issued and not yet returned.
REQ-019 err  out  1  sticky protocol-error flag.

Function
REQ-020 Shall assert cmd_ready = (outstanding < MAX_OUTSTANDING) and not busy, combinationally from the registered count and busy.
REQ-021 Shall drive start = cmd_valid and cmd_ready, and A = cmd_base, both combinationally; start shall never be asserted while busy=1.
REQ-022 A call is accepted on a cycle with start=1; on that edge cmd_tag shall be pushed into the tag FIFO.
REQ-023 Shall drive stall = res_valid and not res_ready.
REQ-024 A return is transferred on a cycle with done=1 and stall=0; on that edge res_data<=returndata, res_tag<=FIFO head, res_valid<=1, and the FIFO head shall be popped.
REQ-025 Latency from return transfer to res_valid=1 shall be exactly 1 cycle.
REQ-026 res_valid shall clear on res_valid and res_ready unless a return transfers the same cycle; back-to-back returns with res_ready=1 shall sustain one result per cycle.
REQ-027 res_data and res_tag shall hold stable while res_valid=1 and res_ready=0.
REQ-028 Outstanding count: +1 on call accept only, -1 on return transfer only, unchanged on both or neither.
REQ-029 Results shall be tagged in call-acceptance order, since loop_pipeline returns in order.
REQ-030 A return transfer with outstanding=0 shall set err, shall not update res_valid, res_data or res_tag, and shall not decrement the count, even if a call is accepted the same cycle; that call's tag is still pushed.
REQ-031 Full boundary: at outstanding=MAX_OUTSTANDING, cmd_ready=0 until a return transfers; the freed slot becomes usable the following cycle (no same-cycle bypass).
REQ-032 FIFO pointers shall wrap modulo MAX_OUTSTANDING; no tag shall be lost or duplicated across wrap.
REQ-033 err shall remain set until reset.

Reset
REQ-034 On reset=1 at a clock edge: outstanding=0, FIFO pointers=0, res_valid=0, res_data=0, res_tag=0, err=0.
REQ-035 While reset=1, cmd_ready=0 and start=0; stall shall follow REQ-023, which gives 0.
REQ-036 Reset mid-operation shall discard all in-flight tags and any pending result; loop_pipeline shares this reset domain, so no stale return is expected afterwards.

Verification
REQ-037 Single call: cmd_base=0x1000, tag=0x5A, busy=0; done with returndata=0x00ABC two cycles later -> res_valid next cycle, res_data=0x00ABC, res_tag=0x5A, outstanding back to 0.
REQ-038 Fill: 5 commands with MAX_OUTSTANDING=4, no returns -> 4 accepted, cmd_ready=0, outstanding=4; one return -> 5th accepted the cycle after.
REQ-039 Backpressure: res_ready=0 with result pending, done=1 -> stall=1, res_data stable, no FIFO pop; res_ready=1 -> next result loads the same cycle.
REQ-040 Ordering and wrap: 10 calls with tags 0..9, returns interleaved, res_ready=1 -> res_tag sequence 0..9, no gaps or duplicates.
REQ-041 Error: done=1 with outstanding=0 -> err=1, res_valid stays 0; err holds until reset.
REQ-042 Busy gating plus mid-run reset: busy=1 with cmd_valid=1 -> start=0; reset with 3 outstanding -> outstanding=0, res_valid=0, err=0.
